// File: rtl/adc_sampler_if.sv
// Bundle between adc_sampler and its environment: the SPI pins toward the ADC
// plus the sample output that feeds the filter stage's signalIn.
interface adc_sampler_if;
   logic       enable;
   logic       miso;
   logic       sclk;
   logic       cs_n;
   logic       mosi;
   logic [7:0] sample;
   logic       sample_valid;
   logic       busy;
   logic [1:0] state;

   // sample_valid is a one-cycle strobe with no backpressure (no ready): the
   // consumer must take sample that cycle; sample then holds until the next strobe.
   modport master (
      input  enable, miso,
      output sclk, cs_n, mosi, sample, sample_valid, busy, state
   );

   modport slave (
      output enable, miso,
      input  sclk, cs_n, mosi, sample, sample_valid, busy, state
   );
endinterface

// File: rtl/adc_sampler.sv
// Periodic MCP3008-style SPI conversion; delivers code[9:2] with a one-cycle
// valid strobe. The conversion period is fixed, so it defines the filter sample rate.
module adc_sampler #(
   parameter int         CLK_DIV       = 4,
   parameter int         SAMPLE_PERIOD = 1000,
   parameter logic [2:0] CHANNEL       = 3'd0
) (
   input  logic          clk,
   input  logic          reset,
   adc_sampler_if.master bus
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

   state_t        state;
   logic [PW-1:0] pcnt;
   logic          tick;
   logic [CW-1:0] cnt;
   logic          last;
   logic [3:0]    k;
   logic          high;
   logic [9:0]    shreg;
   logic          cs_n_q;
   logic          sclk_q;
   logic          mosi_q;
   logic [7:0]    sample_q;
   logic          valid_q;
   logic          busy_q;

   assign tick = bus.enable && (pcnt == PW'(SAMPLE_PERIOD - 1));
   assign last = (cnt == CW'(CLK_DIV - 1));

   // Command frame: start, single-ended, channel MSB first, then zeros.
   function automatic logic cmd_bit(input logic [4:0] idx);
      case (idx)
         5'd0, 5'd1: cmd_bit = 1'b1;
         5'd2:       cmd_bit = CHANNEL[2];
         5'd3:       cmd_bit = CHANNEL[1];
         5'd4:       cmd_bit = CHANNEL[0];
         default:    cmd_bit = 1'b0;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset || !bus.enable) begin
         pcnt <= '0;
      end else if (tick) begin
         pcnt <= '0;
      end else begin
         pcnt <= pcnt + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         k        <= '0;
         high     <= 1'b0;
         shreg    <= '0;
         cs_n_q   <= 1'b1;
         sclk_q   <= 1'b0;
         mosi_q   <= 1'b0;
         sample_q <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (tick) begin
                  state  <= SETUP;
                  cnt    <= '0;
                  cs_n_q <= 1'b0;
                  busy_q <= 1'b1;
                  mosi_q <= cmd_bit(5'd0);
               end
            end
            SETUP: begin
               if (last) begin
                  state  <= SHIFT;
                  cnt    <= '0;
                  k      <= '0;
                  high   <= 1'b1;
                  sclk_q <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            SHIFT: begin
               if (!last) begin
                  cnt <= cnt + CW'(1);
               end else begin
                  cnt <= '0;
                  if (high) begin
                     // End of the high phase: take miso, drop SCLK, present next command bit.
                     shreg  <= {shreg[8:0], bus.miso};
                     high   <= 1'b0;
                     sclk_q <= 1'b0;
                     mosi_q <= cmd_bit({1'b0, k} + 5'd1);
                  end else if (k == 4'd15) begin
                     state    <= DONE;
                     cs_n_q   <= 1'b1;
                     busy_q   <= 1'b0;
                     mosi_q   <= 1'b0;
                     sample_q <= shreg[9:2];
                     valid_q  <= 1'b1;
                  end else begin
                     k      <= k + 4'd1;
                     high   <= 1'b1;
                     sclk_q <= 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.cs_n         = cs_n_q;
   assign bus.sclk         = sclk_q;
   assign bus.mosi         = mosi_q;
   assign bus.sample       = sample_q;
   assign bus.sample_valid = valid_q;
   assign bus.busy         = busy_q;
   assign bus.state        = state;

endmodule

// File: tb/tb_adc_sampler.sv
// Directed bench for adc_sampler: table of conversions at full rate, then
// enable-drop and mid-frame reset sequences against an MCP3008-style ADC model.
module tb_adc_sampler;

   localparam int         CLK_DIV       = 4;
   localparam int         SAMPLE_PERIOD = 200;
   localparam logic [2:0] CHANNEL       = 3'd5;
   localparam int         FRAME         = 33 * CLK_DIV;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   adc_sampler_if ifc ();

   adc_sampler #(
      .CLK_DIV      (CLK_DIV),
      .SAMPLE_PERIOD(SAMPLE_PERIOD),
      .CHANNEL      (CHANNEL)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (ifc)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int base = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int now();
      return cyc - base;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, now());
      end
   endtask

   // ADC model: next bit appears after each falling SCLK; bits 0..5 are noise.
   logic [9:0] model_code = 10'h000;
   int         midx = 0;
   logic       m_prev_cs = 1'b1;
   logic       m_prev_sclk = 1'b0;

   function automatic logic mbit(input int idx);
      if (idx >= 6 && idx <= 15) return model_code[15 - idx];
      return 1'($urandom_range(0, 1));
   endfunction

   always @(negedge clk) begin
      if (ifc.cs_n) begin
         ifc.miso = 1'($urandom_range(0, 1));
      end else if (m_prev_cs) begin
         midx = 0;
         ifc.miso = mbit(0);
      end else if (!ifc.sclk && m_prev_sclk) begin
         midx++;
         ifc.miso = mbit(midx);
      end
      m_prev_cs   = ifc.cs_n;
      m_prev_sclk = ifc.sclk;
   end

   // Frame monitor: cs_n fall time, SCLK rises, mosi at each rise, busy length.
   int          cs_fall_cnt = 0;
   int          last_cs_fall = -1;
   int          rise_cnt = 0;
   int          busy_cnt = 0;
   int          valid_cnt = 0;
   logic [15:0] mosi_bits = '0;
   logic        prev_cs = 1'b1;
   logic        prev_sclk = 1'b0;

   always @(negedge clk) begin
      if (prev_cs && !ifc.cs_n) begin
         cs_fall_cnt++;
         last_cs_fall = now();
         rise_cnt = 0;
         busy_cnt = 0;
         mosi_bits = '0;
      end
      if (ifc.sclk && !prev_sclk) begin
         if (rise_cnt < 16) mosi_bits[15 - rise_cnt] = ifc.mosi;
         rise_cnt++;
      end
      if (ifc.busy) busy_cnt++;
      if (ifc.sample_valid) valid_cnt++;
      prev_cs   = ifc.cs_n;
      prev_sclk = ifc.sclk;
   end

   task automatic start_run();
      reset = 1'b1;
      ifc.enable = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      ifc.enable = 1'b1;
      base = cyc;
   endtask

   task automatic goto(input int n);
      do begin
         @(posedge clk);
         #1;
      end while (now() < n);
   endtask

   task automatic wait_valid(input logic [7:0] hold_exp, input int budget,
                             output int vcyc, output int hold_bad);
      vcyc = -1;
      hold_bad = 0;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         #1;
         if (ifc.sample_valid) begin
            vcyc = now();
            break;
         end
         if (ifc.sample !== hold_exp) hold_bad++;
      end
   endtask

   typedef struct {
      logic [9:0] code;
      logic [7:0] exp_sample;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         vc;
      int         hb;
      int         v0;
      int         f0;
      logic [7:0] hold_exp;

      vecs[0] = '{10'h2A5, 8'hA9};
      vecs[1] = '{10'h3FF, 8'hFF};
      vecs[2] = '{10'h000, 8'h00};
      vecs[3] = '{10'h003, 8'h00};
      vecs[4] = '{10'h155, 8'h55};
      vecs[5] = '{10'h1FC, 8'h7F};

      ifc.enable = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_cs_n", 32'(ifc.cs_n), 32'd1);
      check("rst_sclk", 32'(ifc.sclk), 32'd0);
      check("rst_mosi", 32'(ifc.mosi), 32'd0);
      check("rst_sample", 32'(ifc.sample), 32'd0);
      check("rst_valid", 32'(ifc.sample_valid), 32'd0);
      check("rst_busy", 32'(ifc.busy), 32'd0);
      check("rst_state", 32'(ifc.state), 32'd0);

      // Back-to-back conversions at full rate.
      start_run();
      v0 = valid_cnt;
      hold_exp = 8'h00;
      for (int i = 0; i < 6; i++) begin
         model_code = vecs[i].code;
         wait_valid(hold_exp, SAMPLE_PERIOD + FRAME + 50, vc, hb);
         check("valid_cycle", 32'(vc), 32'(SAMPLE_PERIOD + FRAME + SAMPLE_PERIOD * i));
         check("sample", 32'(ifc.sample), 32'(vecs[i].exp_sample));
         check("sample_hold", 32'(hb), 32'd0);
         check("cs_fall", 32'(last_cs_fall), 32'(SAMPLE_PERIOD + SAMPLE_PERIOD * i));
         check("busy_len", 32'(busy_cnt), 32'(FRAME));
         check("sclk_rises", 32'(rise_cnt), 32'd16);
         check("mosi_cmd", 32'(mosi_bits), 32'h0000_E800);
         hold_exp = vecs[i].exp_sample;
      end
      check("valid_count", 32'(valid_cnt - v0), 32'd6);

      // Enable dropped mid-frame: frame completes, then silence until re-enable.
      start_run();
      model_code = 10'h155;
      f0 = cs_fall_cnt;
      goto(250);
      ifc.enable = 1'b0;
      wait_valid(8'h00, 200, vc, hb);
      check("drop_valid_cycle", 32'(vc), 32'd332);
      check("drop_sample", 32'(ifc.sample), 32'h55);
      check("drop_hold", 32'(hb), 32'd0);
      goto(400);
      check("drop_no_cs", 32'(cs_fall_cnt - f0), 32'd1);
      check("drop_sample_kept", 32'(ifc.sample), 32'h55);
      ifc.enable = 1'b1;
      model_code = 10'h2A5;
      goto(601);
      check("reen_cs_fall", 32'(last_cs_fall), 32'd600);
      check("reen_cs_count", 32'(cs_fall_cnt - f0), 32'd2);

      // Reset in the middle of the frame that began at 600.
      goto(660);
      reset = 1'b1;
      goto(661);
      reset = 1'b0;
      v0 = valid_cnt;
      @(negedge clk);
      #1;
      check("mrst_cs_n", 32'(ifc.cs_n), 32'd1);
      check("mrst_sclk", 32'(ifc.sclk), 32'd0);
      check("mrst_mosi", 32'(ifc.mosi), 32'd0);
      check("mrst_sample", 32'(ifc.sample), 32'd0);
      check("mrst_busy", 32'(ifc.busy), 32'd0);
      check("mrst_state", 32'(ifc.state), 32'd0);
      goto(862);
      check("mrst_no_valid", 32'(valid_cnt - v0), 32'd0);
      check("mrst_next_cs", 32'(last_cs_fall), 32'd861);
      wait_valid(8'h00, 200, vc, hb);
      check("mrst_valid_cycle", 32'(vc), 32'(861 + FRAME));
      check("mrst_sample", 32'(ifc.sample), 32'hA9);
      check("mrst_hold", 32'(hb), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
